// File: rtl/pc_next_ctrl.sv
// Next-PC selection and IF/ID flush/hold control for the fetch stage.
// Optional event counters are compiled in when PC_NEXT_STATS_EN is defined.
module pc_next_ctrl #(
    parameter int PC_WIDTH     = 10,
    parameter int PC_STEP      = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] pc_current,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                load_use_hazard,
    input  logic                halt_instr,
    output logic [PC_WIDTH-1:0] PC_new,
    output logic                PC_write,
    output logic                ifid_write,
    output logic                ifid_flush,
    output logic                halted
`ifdef PC_NEXT_STATS_EN
    ,
    output logic [15:0]         redirect_count,
    output logic [15:0]         stall_count
`endif
);

    localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic                redirect_req;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic [PC_WIDTH-1:0] pc_seq;
    logic                take_redirect;

    assign redirect_req = jump | branch_taken;
    assign redirect_pc  = jump ? jump_target : branch_target;
    // Natural truncation gives the modulo-2^PC_WIDTH wrap.
    assign pc_seq       = pc_current + PC_WIDTH'(PC_STEP);

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        PC_new        = pc_current;
        PC_write      = 1'b0;
        ifid_write    = 1'b0;
        ifid_flush    = 1'b0;
        halted        = 1'b0;
        take_redirect = 1'b0;

        if (reset) begin
            state_d     = ST_RUN;
            flush_cnt_d = '0;
            PC_new      = '0;
            PC_write    = 1'b1;
            ifid_flush  = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (halt_instr) begin
                        ifid_flush = 1'b1;
                        state_d    = ST_HALT;
                    end else if (redirect_req) begin
                        take_redirect = 1'b1;
                    end else if (!load_use_hazard) begin
                        PC_new     = pc_seq;
                        PC_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // ID holds a bubble here, so halt and load-use are meaningless.
                    if (redirect_req) begin
                        take_redirect = 1'b1;
                    end else begin
                        PC_new     = pc_seq;
                        PC_write   = 1'b1;
                        ifid_write = 1'b1;
                        ifid_flush = 1'b1;
                        if (flush_cnt_q <= CNT_W'(1)) begin
                            state_d     = ST_RUN;
                            flush_cnt_d = '0;
                        end else begin
                            flush_cnt_d = flush_cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    ifid_flush = 1'b1;
                    halted     = 1'b1;
                end
                default: begin
                    state_d     = ST_RUN;
                    flush_cnt_d = '0;
                end
            endcase

            if (take_redirect) begin
                PC_new     = redirect_pc;
                PC_write   = 1'b1;
                ifid_write = 1'b1;
                ifid_flush = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_RELOAD;
                end else begin
                    state_d     = ST_RUN;
                    flush_cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef PC_NEXT_STATS_EN
    logic        redirect_acc;
    logic        stall_acc;
    logic [15:0] redirect_count_q, redirect_count_d;
    logic [15:0] stall_count_q, stall_count_d;

    assign redirect_acc = !reset && redirect_req &&
                          ((state_q == ST_FLUSH) || (state_q == ST_RUN && !halt_instr));
    assign stall_acc    = !reset && (state_q == ST_RUN) && !halt_instr &&
                          !redirect_req && load_use_hazard;

    always_comb begin
        redirect_count_d = redirect_count_q;
        stall_count_d    = stall_count_q;
        if (redirect_acc && redirect_count_q != 16'hFFFF) begin
            redirect_count_d = redirect_count_q + 16'd1;
        end
        if (stall_acc && stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            redirect_count_q <= '0;
            stall_count_q    <= '0;
        end else begin
            redirect_count_q <= redirect_count_d;
            stall_count_q    <= stall_count_d;
        end
    end

    assign redirect_count = redirect_count_q;
    assign stall_count    = stall_count_q;
`endif

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Bench for pc_next_ctrl: directed test-plan cases with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pc_next_ctrl;
    localparam int W  = 10;
    localparam int FC = 2;

    logic         clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset = 1'b1;
    logic [W-1:0] pc_reg = 10'd5;
    logic         jump = 1'b0, branch_taken = 1'b0, load_use_hazard = 1'b0, halt_instr = 1'b0;
    logic [W-1:0] jump_target = '0, branch_target = '0;

    wire  [W-1:0] PC_new;
    wire          PC_write, ifid_write, ifid_flush, halted;
`ifdef PC_NEXT_STATS_EN
    wire  [15:0]  redirect_count, stall_count;
`endif

    pc_next_ctrl #(.PC_WIDTH(W), .PC_STEP(1), .FLUSH_CYCLES(FC)) dut (
        .clock           (clock),
        .reset           (reset),
        .pc_current      (pc_reg),
        .jump            (jump),
        .jump_target     (jump_target),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .load_use_hazard (load_use_hazard),
        .halt_instr      (halt_instr),
        .PC_new          (PC_new),
        .PC_write        (PC_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .halted          (halted)
`ifdef PC_NEXT_STATS_EN
        ,
        .redirect_count  (redirect_count),
        .stall_count     (stall_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model state: halted flag, flush cycles still owed after the redirect cycle, event counts.
    bit           m_halted = 1'b0;
    int           m_flush_left = 0;
    int           m_redir = 0, m_stall = 0;
    bit           n_halted;
    int           n_flush_left, n_redir, n_stall;
    logic [W-1:0] e_new;
    bit           e_write, e_iw, e_fl, e_h;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_eval();
        n_halted     = m_halted;
        n_flush_left = m_flush_left;
        n_redir      = m_redir;
        n_stall      = m_stall;
        e_new = pc_reg; e_write = 0; e_iw = 0; e_fl = 0; e_h = 0;
        if (reset) begin
            e_new = '0; e_write = 1; e_fl = 1;
            n_halted = 0; n_flush_left = 0; n_redir = 0; n_stall = 0;
        end else if (m_halted) begin
            e_fl = 1; e_h = 1;
        end else if (m_flush_left == 0 && halt_instr) begin
            e_fl = 1; n_halted = 1;
        end else if (jump || branch_taken) begin
            e_new = jump ? jump_target : branch_target;
            e_write = 1; e_iw = 1; e_fl = 1;
            n_flush_left = FC - 1;
            n_redir = sat(m_redir + 1);
        end else if (m_flush_left == 0 && load_use_hazard) begin
            n_stall = sat(m_stall + 1);
        end else begin
            e_new = W'((int'(pc_reg) + 1) % 1024);
            e_write = 1; e_iw = 1;
            e_fl = (m_flush_left > 0);
            if (m_flush_left > 0) n_flush_left = m_flush_left - 1;
        end
    endtask

    task automatic compare();
        chk("PC_new", 32'(PC_new), 32'(e_new));
        chk("PC_write", 32'(PC_write), 32'(e_write));
        chk("ifid_write", 32'(ifid_write), 32'(e_iw));
        chk("ifid_flush", 32'(ifid_flush), 32'(e_fl));
        chk("halted", 32'(halted), 32'(e_h));
`ifdef PC_NEXT_STATS_EN
        chk("redirect_count", 32'(redirect_count), 32'(m_redir));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
`endif
    endtask

    // Apply one cycle of inputs away from the rising edge, then check against the model.
    task automatic drive(input bit r, input bit j, input int jt, input bit b, input int bt,
                         input bit lu, input bit h);
        @(negedge clock);
        reset = r; jump = j; jump_target = W'(jt); branch_taken = b; branch_target = W'(bt);
        load_use_hazard = lu; halt_instr = h;
        #1;
        model_eval();
        compare();
    endtask

    // Clock edge: the bench's PC register loads like the real one, and the model advances.
    task automatic step();
        @(posedge clock);
        #1;
        if (e_write) pc_reg = e_new;
        m_halted = n_halted; m_flush_left = n_flush_left;
        m_redir = n_redir; m_stall = n_stall;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset for two cycles with the PC fed back.
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            chk("lit_reset_pc", 32'(PC_new), 32'd0);
            chk("lit_reset_ifid_write", 32'(ifid_write), 32'd0);
            step();
        end
        // Sequential run 0,1,2,3.
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("lit_seq_pc", 32'(PC_new), 32'(i + 1));
            chk("lit_seq_flush", 32'(ifid_flush), 32'd0);
            step();
        end
        // Wrap at the top of the address space.
        pc_reg = 10'd1023;
        idle();
        chk("lit_wrap_pc", 32'(PC_new), 32'd0);
        chk("lit_wrap_write", 32'(PC_write), 32'd1);
        step();
        // Branch with a two-cycle flush.
        pc_reg = 10'd7;
        drive(0, 0, 0, 1, 40, 0, 0);
        chk("lit_br_pc", 32'(PC_new), 32'd40);
        chk("lit_br_flush", 32'(ifid_flush), 32'd1);
        step();
        idle();
        chk("lit_br_pc1", 32'(PC_new), 32'd41);
        chk("lit_br_flush1", 32'(ifid_flush), 32'd1);
        step();
        idle();
        chk("lit_br_pc2", 32'(PC_new), 32'd42);
        chk("lit_br_flush2", 32'(ifid_flush), 32'd0);
        step();
        // Priority: jump beats branch and stall.
        drive(0, 1, 100, 1, 200, 1, 0);
        chk("lit_prio_pc", 32'(PC_new), 32'd100);
        chk("lit_prio_write", 32'(PC_write), 32'd1);
        step();
        idle();
        step();
        // Load-use stall for two cycles at PC 12.
        pc_reg = 10'd12;
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            chk("lit_lu_write", 32'(PC_write), 32'd0);
            chk("lit_lu_ifid", 32'(ifid_write), 32'd0);
            chk("lit_lu_pc", 32'(PC_new), 32'd12);
            step();
        end
        idle();
        chk("lit_lu_resume", 32'(PC_new), 32'd13);
        step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) pc_reg = W'($urandom_range(1000, 1023));
            drive($urandom_range(0, 59) == 0,
                  $urandom_range(0, 7) == 0, int'($urandom_range(0, 1023)),
                  $urandom_range(0, 5) == 0, int'($urandom_range(0, 1023)),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 49) == 0);
            step();
        end

        // Halt and recovery.
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        pc_reg = 10'd20;
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("lit_halt_write", 32'(PC_write), 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 300, 0, 0, 0, 0);
            chk("lit_halted", 32'(halted), 32'd1);
            chk("lit_halt_hold", 32'(PC_write), 32'd0);
            chk("lit_halt_pc", 32'(PC_new), 32'd20);
            step();
        end
        drive(1, 1, 300, 0, 0, 0, 0);
        chk("lit_rec_halted", 32'(halted), 32'd0);
        chk("lit_rec_pc", 32'(PC_new), 32'd0);
        step();
        idle();
        chk("lit_rec_seq", 32'(PC_new), 32'd1);
`ifdef PC_NEXT_STATS_EN
        chk("lit_rec_redir_cnt", 32'(redirect_count), 32'd0);
        chk("lit_rec_stall_cnt", 32'(stall_count), 32'd0);
`endif
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_next_ctrl.md
Name: pc_next_ctrl

Overview:
- Drives the write side of the instruction-fetch PC register: produces PC_new and PC_write every cycle.
- Selects between sequential fetch, jump, branch redirect, load-use stall and halt.
- Issues IF/ID flush/hold controls so the pipeline register stays consistent with the PC.
- Sits between the ID-stage branch/hazard logic and the PC/IF-ID registers of the MIPS-DLX fetch stage.

Parameters:
- PC_WIDTH, 10, width of the instruction word address (instruction memory depth 2^PC_WIDTH words).
- PC_STEP, 1, increment per sequential fetch, in words.
- FLUSH_CYCLES, 1, number of cycles IF/ID is flushed after a redirect (1..3).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_current  in  PC_WIDTH  current PC register output.
- jump  in  1  unconditional jump resolved in ID this cycle.
- jump_target  in  PC_WIDTH  jump destination.
- branch_taken  in  1  conditional branch resolved taken in ID this cycle.
- branch_target  in  PC_WIDTH  branch destination.
- load_use_hazard  in  1  ID instruction depends on a load in EX.
- halt_instr  in  1  halt opcode decoded in ID.
- PC_new  out  PC_WIDTH  next PC value presented to the PC register.
- PC_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID register load enable (0 = hold).
- ifid_flush  out  1  IF/ID register clear to NOP.
- halted  out  1  core halted; fetch frozen.

Behaviour:
- Combinational outputs: PC_new, PC_write, ifid_write and ifid_flush are combinational functions of the registered state and the current inputs. They take effect at the next rising edge, when the PC samples them.
- States: RUN, FLUSH, HALT. A flush counter of width ceil(log2(FLUSH_CYCLES+1)) is also kept.
- Reset (synchronous, priority over everything):
  - State becomes RUN and the flush counter 0.
  - While reset is high, outputs are forced to PC_new=0, PC_write=1, ifid_write=0, ifid_flush=1, halted=0.
  - This drives the PC to 0 on the reset edge.
- Input priority within a cycle (outside HALT): halt_instr > jump > branch_taken > load_use_hazard > sequential.
- halt_instr:
  - Outputs PC_write=0, ifid_write=0, ifid_flush=1.
  - Next state HALT.
- jump or branch_taken (redirect):
  - PC_new = jump_target if jump, else branch_target. PC_write=1, ifid_flush=1.
  - Next state FLUSH with counter = FLUSH_CYCLES-1. If FLUSH_CYCLES=1, next state is RUN.
- load_use_hazard (with no redirect and no halt):
  - PC_write=0, ifid_write=0, ifid_flush=0: PC and IF/ID hold for exactly that cycle.
  - Stall lasts as long as the input stays high; no internal count.
- Sequential fetch: PC_new = pc_current + PC_STEP modulo 2^PC_WIDTH (1023+1 wraps to 0), PC_write=1, ifid_write=1, ifid_flush=0.
- FLUSH state:
  - Sequential fetch with ifid_flush=1; the counter decrements each cycle, and the state returns to RUN when it reaches 0.
  - A new redirect in FLUSH is accepted and reloads the counter.
  - load_use_hazard is ignored in FLUSH, because the ID instruction is a bubble.
  - halt_instr is ignored in FLUSH.
- HALT state:
  - PC_write=0, ifid_write=0, ifid_flush=1, halted=1.
  - All inputs are ignored; the only exit is reset.
- Whenever the PC is not written, PC_new equals pc_current.
- Reset asserted mid-stall or mid-flush wins immediately; no residual flush remains after reset deasserts.

Optional Feature:
- Macro: PC_NEXT_STATS_EN.
- When defined, adds outputs redirect_count[15:0] and stall_count[15:0]. Both reset to 0 on reset and saturate at 16'hFFFF.
  - redirect_count increments in each cycle a redirect is accepted.
  - stall_count increments in each cycle a load-use stall holds the PC.
  - Neither counter changes in HALT.
- When not defined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Reset then run: reset high 2 cycles, PC model fed back → PC_new=0 during reset; after release, PC sequence 0,1,2,3 with ifid_write=1 and ifid_flush=0.
- Wrap: pc_current=1023 in RUN → PC_new=0, PC_write=1.
- Branch with FLUSH_CYCLES=2: branch_taken=1, branch_target=40 at PC=7 → PC_new=40, ifid_flush=1 that cycle and the next, then RUN with PC 41,42.
- Priority: jump=1 (target 100), branch_taken=1 (target 200) and load_use_hazard=1 in the same cycle → PC_new=100, PC_write=1, stall ignored.
- Load-use: hazard high 2 cycles at PC=12 → PC_write=0 and ifid_write=0 for both cycles, PC stays 12, then resumes at 13.
- Halt and recovery: halt_instr at PC=20 → halted=1 and PC_write=0 indefinitely, even with jump=1; reset → halted=0, PC_new=0. With PC_NEXT_STATS_EN, the counters read 0 after reset.
